// File: rtl/m_mux_scan.sv
// Registered N-channel, W-bit multiplexer with a direct select-driven mode and a
// round-robin scan mode stepping through every channel at a programmable rate.
module m_mux_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SCAN_DIV = 1,
  localparam int unsigned SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [SELW-1:0]           SEL,
  input  logic                      MODE,
  input  logic                      EN,
  input  logic                      HOLD,
  output logic [WIDTH-1:0]          Q,
  output logic [SELW-1:0]           QCH,
  output logic                      QV,
  output logic                      WRAP
);

  localparam int unsigned DivW     = 16;
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [SELW-1:0] PtrLast = SELW'(CHANNELS - 1);

  typedef enum logic [1:0] {
    StDirect,
    StScanStart,
    StScan
  } state_e;

  state_e          state_q;
  logic [SELW-1:0] ptr_q;
  logic [DivW-1:0] div_q;

  logic [SELW-1:0]  ptr_eff;
  logic [DivW-1:0]  div_eff;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] ptr_data;

  // Out-of-range indices (non-power-of-2 CHANNELS) fall through to zero.
  function automatic logic [WIDTH-1:0] pick(input logic [SELW-1:0] idx);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (idx == SELW'(k)) r = D[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

  // SCAN_START behaves as a scan cycle seen from a freshly cleared ptr/div.
  always_comb begin
    ptr_eff  = (state_q == StScanStart) ? '0 : ptr_q;
    div_eff  = (state_q == StScanStart) ? '0 : div_q;
    sel_data = pick(SEL);
    ptr_data = pick(ptr_eff);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StDirect;
      ptr_q   <= '0;
      div_q   <= '0;
      Q       <= '0;
      QCH     <= '0;
      QV      <= 1'b0;
      WRAP    <= 1'b0;
    end else if (HOLD) begin
      QV   <= 1'b0;
      WRAP <= 1'b0;
    end else begin
      QV   <= 1'b0;
      WRAP <= 1'b0;
      unique case (state_q)
        StDirect: begin
          if (MODE) begin
            state_q <= StScanStart;
          end else if (EN) begin
            Q   <= sel_data;
            QCH <= SEL;
            QV  <= 1'b1;
          end
        end
        StScanStart, StScan: begin
          if (!MODE) begin
            state_q <= StDirect;
          end else begin
            state_q <= StScan;
            ptr_q   <= ptr_eff;
            div_q   <= div_eff;
            if (EN) begin
              if (div_eff == DivLast) begin
                Q     <= ptr_data;
                QCH   <= ptr_eff;
                QV    <= 1'b1;
                WRAP  <= (ptr_eff == PtrLast);
                div_q <= '0;
                ptr_q <= (ptr_eff == PtrLast) ? '0 : ptr_eff + 1'b1;
              end else begin
                div_q <= div_eff + 1'b1;
              end
            end
          end
        end
        default: state_q <= StDirect;
      endcase
    end
  end

endmodule

// File: tb/tb_m_mux_scan.sv
// Scoreboard bench for m_mux_scan: a 4-channel/div-3 instance and a 3-channel/div-1 instance.
module tb_m_mux_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] d4;
  logic [1:0]  sel4;
  logic        mode4, en4, hold4;
  logic [7:0]  q4;
  logic [1:0]  qch4;
  logic        qv4, wrap4;

  logic [23:0] d3;
  logic [1:0]  sel3;
  logic        mode3, en3, hold3;
  logic [7:0]  q3;
  logic [1:0]  qch3;
  logic        qv3, wrap3;

  m_mux_scan #(.WIDTH(8), .CHANNELS(4), .SCAN_DIV(3)) u_dut4 (
    .CLK(clk), .RESET(rst), .D(d4), .SEL(sel4), .MODE(mode4), .EN(en4), .HOLD(hold4),
    .Q(q4), .QCH(qch4), .QV(qv4), .WRAP(wrap4)
  );

  m_mux_scan #(.WIDTH(8), .CHANNELS(3), .SCAN_DIV(1)) u_dut3 (
    .CLK(clk), .RESET(rst), .D(d3), .SEL(sel3), .MODE(mode3), .EN(en3), .HOLD(hold3),
    .Q(q3), .QCH(qch3), .QV(qv3), .WRAP(wrap3)
  );

  typedef struct {
    int         cyc;
    logic [7:0] q;
    logic [1:0] qch;
    logic       wrap;
  } exp_t;

  exp_t sb4[$];
  exp_t sb3[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void push4(input int c, input logic [7:0] q, input logic [1:0] ch,
                                input logic w);
    exp_t e;
    e.cyc = c; e.q = q; e.qch = ch; e.wrap = w;
    sb4.push_back(e);
  endfunction

  function automatic void push3(input int c, input logic [7:0] q, input logic [1:0] ch,
                                input logic w);
    exp_t e;
    e.cyc = c; e.q = q; e.qch = ch; e.wrap = w;
    sb3.push_back(e);
  endfunction

  always @(negedge clk) begin : mon4
    exp_t e;
    if (!rst) begin
      if (qv4) begin
        checks++;
        if (sb4.size() == 0) begin
          failures++;
          $display("FAIL dut4_unexpected_strobe: cyc=%0d q=%0h qch=%0d", cyc, q4, qch4);
        end else begin
          e = sb4.pop_front();
          if (e.cyc != cyc || q4 !== e.q || qch4 !== e.qch || wrap4 !== e.wrap) begin
            failures++;
            $display("FAIL dut4_sample: got cyc=%0d q=%0h qch=%0d wrap=%0b expected cyc=%0d q=%0h qch=%0d wrap=%0b",
                     cyc, q4, qch4, wrap4, e.cyc, e.q, e.qch, e.wrap);
          end
        end
      end else begin
        if (wrap4) begin
          checks++;
          failures++;
          $display("FAIL dut4_wrap_without_qv: cyc=%0d got wrap=1 expected 0", cyc);
        end
        if (sb4.size() > 0 && sb4[0].cyc <= cyc) begin
          e = sb4.pop_front();
          checks++;
          failures++;
          $display("FAIL dut4_missed_strobe: got qv=0 at cyc=%0d expected qch=%0d at cyc=%0d",
                   cyc, e.qch, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst) begin
      if (qv3) begin
        checks++;
        if (sb3.size() == 0) begin
          failures++;
          $display("FAIL dut3_unexpected_strobe: cyc=%0d q=%0h qch=%0d", cyc, q3, qch3);
        end else begin
          e = sb3.pop_front();
          if (e.cyc != cyc || q3 !== e.q || qch3 !== e.qch || wrap3 !== e.wrap) begin
            failures++;
            $display("FAIL dut3_sample: got cyc=%0d q=%0h qch=%0d wrap=%0b expected cyc=%0d q=%0h qch=%0d wrap=%0b",
                     cyc, q3, qch3, wrap3, e.cyc, e.q, e.qch, e.wrap);
          end
        end
      end else if (sb3.size() > 0 && sb3[0].cyc <= cyc) begin
        e = sb3.pop_front();
        checks++;
        failures++;
        $display("FAIL dut3_missed_strobe: got qv=0 at cyc=%0d expected qch=%0d at cyc=%0d",
                 cyc, e.qch, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    d4 = 32'h3322_1100; sel4 = '0; mode4 = 1'b0; en4 = 1'b0; hold4 = 1'b0;
    d3 = 24'hCC_BB_AA;  sel3 = '0; mode3 = 1'b0; en3 = 1'b0; hold3 = 1'b0;
    #12 rst = 1'b0;
    tick();

    // 3-channel instance: out-of-range select, then a div-1 scan
    en3 = 1'b1; sel3 = 2'd3; push3(cyc + 1, 8'h00, 2'd3, 1'b0);
    tick();
    sel3 = 2'd2; push3(cyc + 1, 8'hCC, 2'd2, 1'b0);
    tick();
    mode3 = 1'b1; sel3 = 2'd0;
    push3(cyc + 2, 8'hAA, 2'd0, 1'b0);
    push3(cyc + 3, 8'hBB, 2'd1, 1'b0);
    push3(cyc + 4, 8'hCC, 2'd2, 1'b1);
    push3(cyc + 5, 8'hAA, 2'd0, 1'b0);
    tick(5);
    mode3 = 1'b0; en3 = 1'b0;
    tick(2);

    // Load 0xA5, then assert reset mid-cycle: outputs clear with no clock edge
    d4 = 32'h3322_A500; sel4 = 2'd1; en4 = 1'b1; push4(cyc + 1, 8'hA5, 2'd1, 1'b0);
    tick();
    en4 = 1'b0; d4 = 32'h3322_1100;
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_q", q4, 32'h0);
    chk("async_reset_qch", qch4, 32'h0);
    chk("async_reset_qv", qv4, 32'h0);
    chk("async_reset_wrap", wrap4, 32'h0);
    rst = 1'b0;
    tick();

    // Direct mode
    en4 = 1'b1; sel4 = 2'd2; push4(cyc + 1, 8'h22, 2'd2, 1'b0);
    tick();
    sel4 = 2'd1; push4(cyc + 1, 8'h11, 2'd1, 1'b0);
    tick();
    en4 = 1'b0;
    tick();
    chk("direct_en0_qv", qv4, 32'h0);
    chk("direct_en0_q_hold", q4, 32'h11);
    chk("direct_en0_qch_hold", qch4, 32'h1);

    // Scan, div 3: first sample four edges after MODE rises
    mode4 = 1'b1; en4 = 1'b1; base = cyc;
    for (int i = 0; i < 5; i++) begin
      push4(base + 4 + 3 * i, 8'(8'h11 * (i % 4)), 2'(i % 4), (i % 4) == 3);
    end
    tick(16);

    // EN low for two edges stretches the interval to five
    en4 = 1'b0;
    tick(2);
    en4 = 1'b1;
    push4(base + 21, 8'h11, 2'd1, 1'b0);
    push4(base + 24, 8'h22, 2'd2, 1'b0);
    tick(6);

    // HOLD for four edges, with a MODE glitch that must be ignored
    hold4 = 1'b1;
    tick();
    mode4 = 1'b0;
    tick(2);
    mode4 = 1'b1;
    tick();
    hold4 = 1'b0;
    chk("hold_q_frozen", q4, 32'h22);
    chk("hold_qch_frozen", qch4, 32'h2);
    push4(base + 31, 8'h33, 2'd3, 1'b1);
    push4(base + 34, 8'h00, 2'd0, 1'b0);
    tick(6);

    // MODE 1->0->1 restarts the scan at channel 0
    mode4 = 1'b0;
    tick();
    mode4 = 1'b1;
    push4(cyc + 4, 8'h00, 2'd0, 1'b0);
    tick(6);

    // Reset mid-scan; MODE stays high so the scan restarts from channel 0
    #1 rst = 1'b1;
    #1;
    chk("scan_reset_q", q4, 32'h0);
    chk("scan_reset_qv", qv4, 32'h0);
    rst = 1'b0;
    push4(cyc + 4, 8'h00, 2'd0, 1'b0);
    push4(cyc + 7, 8'h11, 2'd1, 1'b0);
    tick(7);

    en4 = 1'b0; mode4 = 1'b0;
    tick(3);
    chk("sb4_drained", sb4.size(), 32'h0);
    chk("sb3_drained", sb3.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
